// File: rtl/orao_tape_pkg.sv
// orao_tape_pkg: FSM encoding and tape timing defaults shared by the Orao TAP player.
package orao_tape_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LEADER, ST_DATA, ST_DONE} state_t;
  localparam int HALF1_DEF = 208;
  localparam int HALF0_DEF = 416;
  localparam int LEADER_BITS_DEF = 256;
  localparam int CNT_W = 9;
  function automatic int bit_ticks(input int half1);
    return 4 * half1;
  endfunction
endpackage

// File: rtl/orao_fsk_bitgen.sv
// orao_fsk_bitgen: serialises one offered bit at a time as FSK; level and timing freeze while no bit is offered.
module orao_fsk_bitgen
  import orao_tape_pkg::*;
#(
  parameter int HALF1 = HALF1_DEF,
  parameter int HALF0 = HALF0_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ce_1m,
  input  logic clr,
  input  logic bit_val,
  input  logic bit_valid,
  output logic tape_out,
  output logic bit_done
);
  logic [CNT_W-1:0] cnt, cur, half;
  logic [1:0] hc;
  logic fresh, tick, half_end;
  // a fresh bit takes its half-period from the bit value without spending a tick on loading
  always_comb begin
    half = bit_val ? CNT_W'(HALF1 - 1) : CNT_W'(HALF0 - 1);
    cur = fresh ? half : cnt;
    tick = ce_1m && bit_valid;
    half_end = tick && cur == '0;
    bit_done = half_end && hc == (bit_val ? 2'd3 : 2'd1);
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      hc <= '0;
      fresh <= 1'b1;
      tape_out <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      hc <= '0;
      fresh <= 1'b1;
      tape_out <= 1'b0;
    end else if (tick) begin
      cnt <= half_end ? half : cur - 1'b1;
      hc <= bit_done ? 2'd0 : hc + 2'(half_end);
      fresh <= bit_done;
      tape_out <= tape_out ^ half_end;
    end
endmodule

// File: rtl/orao_tap_player.sv
// orao_tap_player: plays an SDRAM-resident TAP image as an Orao FSK tape signal,
// fetching one byte ahead of the LSB-first bit serialiser.
module orao_tap_player
  import orao_tape_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int HALF1 = HALF1_DEF,
  parameter int HALF0 = HALF0_DEF,
  parameter int LEADER_BITS = LEADER_BITS_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_1m,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] tap_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              mem_ready,
  output logic              tape_out,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic [ADDR_W-1:0] len;
  logic [15:0] ldr;
  logic [7:0] sh, pbuf;
  logic [2:0] bidx;
  logic sh_v, pbuf_v, bit_val, bit_valid, bit_done, last, clr;

  assign busy = state == ST_LEADER || state == ST_DATA;
  assign done = state == ST_DONE;
  // after an underrun the first bit of the new byte is served straight from the prefetch buffer
  assign bit_valid = state == ST_LEADER || (state == ST_DATA && (sh_v || pbuf_v));
  assign bit_val = state == ST_DATA && (sh_v ? sh[0] : pbuf[0]);
  assign last = mem_addr == len && !pbuf_v && !mem_rd;
  assign clr = !(state_n == ST_LEADER || state_n == ST_DATA);

  orao_fsk_bitgen #(.HALF1(HALF1), .HALF0(HALF0)) u_bitgen (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_1m(ce_1m), .clr(clr),
    .bit_val(bit_val), .bit_valid(bit_valid), .tape_out(tape_out), .bit_done(bit_done)
  );

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (start) state_n = tap_len == '0 ? ST_DONE : ST_LEADER;
      ST_LEADER: if (bit_done && ldr == 16'(LEADER_BITS - 1)) state_n = ST_DATA;
      ST_DATA:   if (bit_done && sh_v && bidx == 3'd7 && last) state_n = ST_DONE;
      default:   state_n = ST_IDLE;
    endcase
    if (stop) state_n = ST_IDLE;
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      len <= '0;
      mem_addr <= '0;
      mem_rd <= 1'b0;
      ldr <= '0;
      sh <= '0;
      pbuf <= '0;
      sh_v <= 1'b0;
      pbuf_v <= 1'b0;
      bidx <= '0;
    end else if (clr) begin
      mem_rd <= 1'b0;
      sh_v <= 1'b0;
      pbuf_v <= 1'b0;
    end else if (state == ST_IDLE) begin
      len <= tap_len;
      mem_addr <= '0;
      mem_rd <= 1'b1;
      ldr <= '0;
    end else begin
      if (mem_rd && mem_ready) begin
        pbuf <= mem_data;
        pbuf_v <= 1'b1;
        mem_rd <= 1'b0;
        mem_addr <= mem_addr + 1'b1;
      end else if (!mem_rd && !pbuf_v && mem_addr < len) mem_rd <= 1'b1;
      if (state == ST_LEADER && bit_done) ldr <= ldr + 1'b1;
      if (state == ST_DATA && !sh_v && pbuf_v) begin
        sh <= bit_done ? pbuf >> 1 : pbuf;
        bidx <= {2'b0, bit_done};
        sh_v <= 1'b1;
        pbuf_v <= 1'b0;
      end else if (state == ST_DATA && bit_done) begin
        sh <= bidx == 3'd7 ? pbuf : sh >> 1;
        bidx <= bidx + 1'b1;
        if (bidx == 3'd7) begin
          sh_v <= pbuf_v;
          pbuf_v <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_orao_tap_player.sv
// tb_orao_tap_player: randomized playback runs checked against a half-period duration model of the TAP image.
module tb_orao_tap_player;
  localparam int AW = 16, H1 = 2, H0 = 4, LB = 4;
  logic clk_sys = 1'b0, reset_n = 1'b0, ce_1m = 1'b0, start = 1'b0, stop = 1'b0, mem_ready = 1'b0;
  logic mem_rd, tape_out, busy, done;
  logic [AW-1:0] tap_len = '0, mem_addr;
  logic [7:0] mem_data = '0;
  logic [7:0] mem [256];
  int checks = 0, errors = 0;
  int lat = 3, stall_addr = -1, stall_cyc = 0, ce_per = 0, ce_c = 0, mw = 0;
  bit mem_auto = 1'b1, pend = 1'b0;
  int reads[$], iv[$], exp_iv[$];
  int ticks = 0, dn_cnt = 0;
  logic prev_tape = 1'b0;

  orao_tap_player #(.ADDR_W(AW), .HALF1(H1), .HALF0(H0), .LEADER_BITS(LB)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_1m(ce_1m), .start(start), .stop(stop),
    .tap_len(tap_len), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .tape_out(tape_out), .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    ce_c = (ce_c + 1) % (ce_per > 0 ? ce_per : 1);
    ce_1m = ce_per > 0 ? ce_c == 0 : $urandom_range(0, 2) == 0;
  end

  always @(negedge clk_sys) if (mem_auto) begin
    mem_ready = 1'b0;
    if (!mem_rd) pend = 1'b0;
    else begin
      if (!pend) begin
        pend = 1'b1;
        mw = int'(mem_addr) == stall_addr ? stall_cyc : lat;
      end
      if (mw == 0) begin
        mem_ready = 1'b1;
        mem_data = mem[mem_addr[7:0]];
        reads.push_back(int'(mem_addr));
      end else mw--;
    end
  end

  // half-period lengths in ce ticks seen while busy, plus done pulse count
  always @(posedge clk_sys) begin
    if (tape_out !== prev_tape) begin
      iv.push_back(ticks);
      ticks = 0;
      prev_tape = tape_out;
    end
    if (busy === 1'b1 && ce_1m) ticks++;
    if (done === 1'b1) dn_cnt++;
  end

  function automatic void build(input int len);
    exp_iv.delete();
    repeat (2 * LB) exp_iv.push_back(H0);
    for (int b = 0; b < len; b++)
      for (int k = 0; k < 8; k++)
        if (mem[b][k]) repeat (4) exp_iv.push_back(H1);
        else repeat (2) exp_iv.push_back(H0);
  endfunction

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_play(input string nm, input int len, input bit spam);
    int c = 0, sidx = -1, ext = 0, bad = 0, bi = -1;
    build(len);
    if (stall_addr >= 0 && stall_addr < len) begin
      sidx = 2 * LB;
      for (int b = 0; b < stall_addr; b++)
        for (int k = 0; k < 8; k++) sidx += mem[b][k] ? 4 : 2;
    end
    @(negedge clk_sys);
    reads.delete(); iv.delete(); ticks = 0; prev_tape = tape_out; dn_cnt = 0;
    tap_len = AW'(len); start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    while (dn_cnt == 0 && c < 20000) begin
      @(negedge clk_sys); c++;
      start = spam && busy && $urandom_range(0, 15) == 0;
      if (start) tap_len = AW'($urandom_range(1, 9));
    end
    start = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (dn_cnt != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", nm, dn_cnt); end
    checks++;
    if (busy !== 1'b0 || tape_out !== 1'b0) begin
      errors++; $display("FAIL %s idle_outputs busy=%b tape=%b want 0 0", nm, busy, tape_out);
    end
    checks++;
    bad = reads.size() != len;
    foreach (reads[i]) if (reads[i] != i) bad = 1;
    if (bad) begin errors++; $display("FAIL %s reads got %0d reads %p want 0..%0d", nm, reads.size(), reads, len - 1); end
    checks++;
    bad = iv.size() != exp_iv.size();
    if (!bad)
      foreach (iv[i])
        if (i == sidx) ext = iv[i] - exp_iv[i];
        else if (iv[i] != exp_iv[i] && bi < 0) begin bad = 1; bi = i; end
    if (bad) begin
      errors++;
      $display("FAIL %s halves got %0d want %0d first_bad_idx %0d got %0d want %0d", nm, iv.size(), exp_iv.size(),
               bi, bi >= 0 ? iv[bi] : 0, bi >= 0 ? exp_iv[bi] : 0);
    end
    if (sidx >= 0) begin
      checks++;
      if (ext <= 0 || ext > 100) begin errors++; $display("FAIL %s stall_extension got %0d want 1..100", nm, ext); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({mem_rd, tape_out, busy, done} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {mem_rd, tape_out, busy, done});
    end
    checks++;
    if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %0h want 0", mem_addr); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    mem[0] = 8'hA5; mem[1] = 8'h01; lat = 3;
    run_play("basic", 2, 1'b0);
  endtask

  task automatic test_zero_len();
    @(negedge clk_sys);
    reads.delete(); dn_cnt = 0;
    tap_len = '0; start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    checks++;
    if ({done, busy, mem_rd, tape_out} !== 4'b1000) begin
      errors++; $display("FAIL zero_len done/busy/rd/tape got %b want 1000", {done, busy, mem_rd, tape_out});
    end
    repeat (4) @(negedge clk_sys);
    checks++;
    if (done !== 1'b0 || dn_cnt != 1 || reads.size() != 0) begin
      errors++; $display("FAIL zero_len_after done=%b pulses=%0d reads=%0d want 0 1 0", done, dn_cnt, reads.size());
    end
  endtask

  task automatic test_start_stop_same();
    @(negedge clk_sys);
    tap_len = 16'd5; start = 1'b1; stop = 1'b1;
    @(negedge clk_sys); start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL start_stop busy=%b rd=%b want 0 0", busy, mem_rd);
    end
  endtask

  task automatic test_stall();
    fill(3); ce_per = 4; stall_addr = 1; stall_cyc = 400;
    run_play("stall", 3, 1'b0);
    ce_per = 0; stall_addr = -1;
  endtask

  task automatic test_stop();
    int c = 0;
    fill(3); stall_addr = 1; stall_cyc = 100000;
    @(negedge clk_sys);
    tap_len = 16'd3; start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    while (!(mem_rd === 1'b1 && mem_addr === 16'd1) && c < 5000) begin @(negedge clk_sys); c++; end
    checks++;
    if (c >= 5000) begin errors++; $display("FAIL stop_reach_fetch1 rd=%b addr=%0d want 1 1", mem_rd, mem_addr); end
    repeat (5) @(negedge clk_sys);
    mem_auto = 1'b0; mem_ready = 1'b0; dn_cnt = 0;
    stop = 1'b1;
    @(negedge clk_sys); stop = 1'b0;
    checks++;
    if ({mem_rd, busy, tape_out, done} !== 4'b0) begin
      errors++; $display("FAIL stop_next rd/busy/tape/done got %b want 0000", {mem_rd, busy, tape_out, done});
    end
    @(negedge clk_sys); @(negedge clk_sys);
    mem_ready = 1'b1; mem_data = 8'hFF;
    @(negedge clk_sys); mem_ready = 1'b0;
    repeat (5) @(negedge clk_sys);
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0 || dn_cnt != 0) begin
      errors++; $display("FAIL stop_late_ready busy=%b rd=%b pulses=%0d want 0 0 0", busy, mem_rd, dn_cnt);
    end
    mem_auto = 1'b1; stall_addr = -1;
    run_play("after_stop", 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill(4); lat = $urandom_range(1, 5);
    run_play("start_spam", 4, 1'b1);
  endtask

  task automatic test_async_reset();
    int c = 0;
    fill(3);
    @(negedge clk_sys);
    reads.delete();
    tap_len = 16'd3; start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    while (reads.size() < 2 && c < 5000) begin @(negedge clk_sys); c++; end
    repeat (3) @(negedge clk_sys);
    @(posedge clk_sys); #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd, tape_out, busy, done} !== 4'b0 || mem_addr !== '0) begin
      errors++; $display("FAIL async_reset rd/tape/busy/done=%b addr=%0h want 0000 0", {mem_rd, tape_out, busy, done}, mem_addr);
    end
    @(negedge clk_sys); reset_n = 1'b1;
    run_play("after_reset", 3, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 5);
      fill(n); lat = $urandom_range(0, 6);
      run_play($sformatf("rand%0d", r), n, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_start_stop_same();
    test_stall();
    test_stop();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
